// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
// Shared constants and types for the machine-mode trap responder:
// CSR addresses, cause codes, exception bit indices, mstatus field
// positions, FSM state encoding and the small selector enums.
// No ports (package).

package trap_ctrl_pkg;

  // CSR addresses touched by the trap sequence
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values (interrupt flag in bit 31)
  localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

  // Bit positions inside the decode-stage exception vector
  localparam int EXC_MRET  = 0;
  localparam int EXC_ECALL = 1;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MEPC,
    ST_WR_MCAUSE,
    ST_WR_MSTATUS,
    ST_MRET_MSTATUS,
    ST_JUMP
  } state_t;

  // Where the final redirect goes
  typedef enum logic {
    TGT_MTVEC,
    TGT_MEPC
  } tgt_sel_t;

  // Which mstatus transformation the helper sub-module applies
  typedef enum logic {
    MS_TRAP_ENTRY,
    MS_MRET
  } mstatus_mode_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if
// Bundles the trap responder's pipeline/CSR-side signals.
//   exception_i  : decode exception vector (bit1 ecall, bit0 mret)
//   inst_addr_i  : PC of the instruction in decode
//   mtvec_i, mepc_i, mstatus_i : current CSR values
//   timer_irq_i  : level timer interrupt request
//   csr_we_o, csr_waddr_o, csr_wdata_o : CSR file write port
//   stallreq_o   : pipeline stall request
//   jump_flag_o, jump_addr_o : PC redirect
// Modports: master = surrounding pipeline/CSR file, slave = trap_ctrl.

interface trap_ctrl_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
);

  logic [DATA_WIDTH-1:0]     exception_i;
  logic [ADDR_WIDTH-1:0]     inst_addr_i;
  logic [DATA_WIDTH-1:0]     mtvec_i;
  logic [DATA_WIDTH-1:0]     mepc_i;
  logic [DATA_WIDTH-1:0]     mstatus_i;
  logic                      timer_irq_i;
  logic                      csr_we_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o;
  logic [DATA_WIDTH-1:0]     csr_wdata_o;
  logic                      stallreq_o;
  logic                      jump_flag_o;
  logic [ADDR_WIDTH-1:0]     jump_addr_o;

  modport master (
    output exception_i, inst_addr_i, mtvec_i, mepc_i, mstatus_i, timer_irq_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, jump_flag_o, jump_addr_o
  );

  modport slave (
    input  exception_i, inst_addr_i, mtvec_i, mepc_i, mstatus_i, timer_irq_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, jump_flag_o, jump_addr_o
  );

endinterface

// File: rtl/trap_ctrl_mstatus_next.sv
// trap_mstatus_next
// Combinational mstatus rewrite for trap entry and mret.
//   mstatus : current mstatus value
//   mode    : MS_TRAP_ENTRY or MS_MRET
//   next    : value to write back to mstatus
// Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine.
// mret:       MIE <= MPIE, MPIE <= 1, MPP left as is.

module trap_mstatus_next
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mstatus,
  input  mstatus_mode_t         mode,
  output logic [DATA_WIDTH-1:0] next
);

  // Start from the current value so untouched fields pass straight through
  always_comb begin
    next = mstatus;
    if (mode == MS_TRAP_ENTRY) begin
      next[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
      next[MSTATUS_MIE]                   = 1'b0;
      next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end else begin
      next[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      next[MSTATUS_MPIE] = 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Machine-mode trap responder. On ecall it writes mepc, mcause and
// mstatus one per cycle and then redirects to mtvec; on mret it rewrites
// mstatus and redirects to mepc. The pipeline is stalled throughout.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : trap_ctrl_if.slave (exception inputs, CSR values, CSR write
//           port, stall request, PC redirect)
// Optional feature: define TRAP_TIMER_IRQ_EN to let a pending timer
// interrupt (with mstatus.MIE set) start the ecall-style sequence.

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  trap_ctrl_if.slave bus
);

  state_t                state_q, state_d;
  tgt_sel_t              tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;

  logic                  ecall_req;
  logic                  mret_req;
  logic                  irq_req;
  logic                  trap_req;
  mstatus_mode_t         ms_mode;
  logic [DATA_WIDTH-1:0] ms_next;
  logic                  unused_bits;

  assign ecall_req = bus.exception_i[EXC_ECALL];
  assign mret_req  = bus.exception_i[EXC_MRET];

`ifdef TRAP_TIMER_IRQ_EN
  // Interrupt only counts when machine interrupts are globally enabled
  assign irq_req = bus.timer_irq_i & bus.mstatus_i[MSTATUS_MIE];
`else
  assign irq_req = 1'b0;
`endif

  assign trap_req = ecall_req | mret_req | irq_req;

  // Upper exception bits and the mtvec mode bits are deliberately ignored
  assign unused_bits = ^{bus.exception_i[DATA_WIDTH-1:2], bus.mtvec_i[1:0], bus.timer_irq_i};

  trap_mstatus_next #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mstatus_next (
    .mstatus(bus.mstatus_i),
    .mode   (ms_mode),
    .next   (ms_next)
  );

  // State register plus the values captured when a trap is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_MTVEC;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, ecall beats
  // mret, and a synchronous exception beats the timer interrupt
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ecall_req) begin
          state_d = ST_WR_MEPC;
          pc_d    = bus.inst_addr_i;
          cause_d = DATA_WIDTH'(CAUSE_ECALL_M);
          tgt_d   = TGT_MTVEC;
        end else if (mret_req) begin
          state_d = ST_MRET_MSTATUS;
          tgt_d   = TGT_MEPC;
        end else if (irq_req) begin
          state_d = ST_WR_MEPC;
          pc_d    = bus.inst_addr_i;
          cause_d = DATA_WIDTH'(CAUSE_TIMER_IRQ);
          tgt_d   = TGT_MTVEC;
        end
      end
      ST_WR_MEPC:      state_d = ST_WR_MCAUSE;
      ST_WR_MCAUSE:    state_d = ST_WR_MSTATUS;
      ST_WR_MSTATUS:   state_d = ST_JUMP;
      ST_MRET_MSTATUS: state_d = ST_JUMP;
      ST_JUMP:         state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; mtvec/mepc are read live in
  // JUMP so they already reflect writes committed earlier in the sequence
  always_comb begin
    bus.csr_we_o    = 1'b0;
    bus.csr_waddr_o = '0;
    bus.csr_wdata_o = '0;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = '0;
    ms_mode         = MS_TRAP_ENTRY;
    bus.stallreq_o  = (state_q != ST_IDLE) | trap_req;
    unique case (state_q)
      ST_WR_MEPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
        bus.csr_wdata_o = DATA_WIDTH'(pc_q);
      end
      ST_WR_MCAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        bus.csr_wdata_o = cause_q;
      end
      ST_WR_MSTATUS: begin
        ms_mode         = MS_TRAP_ENTRY;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        bus.csr_wdata_o = ms_next;
      end
      ST_MRET_MSTATUS: begin
        ms_mode         = MS_MRET;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        bus.csr_wdata_o = ms_next;
      end
      ST_JUMP: begin
        bus.jump_flag_o = 1'b1;
        if (tgt_q == TGT_MTVEC) begin
          bus.jump_addr_o = {bus.mtvec_i[ADDR_WIDTH-1:2], 2'b00};
        end else begin
          bus.jump_addr_o = bus.mepc_i[ADDR_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
// Self-checking bench for trap_ctrl: a table of per-cycle vectors, a
// reset-abort sequence, a timer-interrupt sequence and a randomized run
// checked against a transaction-level reference model.

module tb_trap_ctrl;

  typedef struct packed {
    logic [31:0] exc;
    logic [31:0] pc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] ms;
    logic        tirq;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
  } resp_t;

  typedef struct packed {
    stim_t stim;
    resp_t exp;
  } vec_t;

`ifdef TRAP_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk_i;
  logic rst_i;
  int   tests;
  int   fails;

  vec_t  vecs[$];
  resp_t exp_q[$];

  trap_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

  trap_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CSR_ADDR_WIDTH(12)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  // 10 time-unit clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic stim_t mk(input logic [31:0] exc, input logic [31:0] pc,
                               input logic [31:0] mtvec, input logic [31:0] mepc,
                               input logic [31:0] ms, input logic tirq);
    stim_t s;
    s.exc = exc; s.pc = pc; s.mtvec = mtvec; s.mepc = mepc; s.ms = ms; s.tirq = tirq;
    return s;
  endfunction

  function automatic resp_t r_idle(input logic stall);
    resp_t r;
    r = '0;
    r.stall = stall;
    return r;
  endfunction

  function automatic resp_t r_wr(input logic [11:0] addr, input logic [31:0] data);
    resp_t r;
    r = '0;
    r.we = 1'b1; r.waddr = addr; r.wdata = data; r.stall = 1'b1;
    return r;
  endfunction

  function automatic resp_t r_jmp(input logic [31:0] addr);
    resp_t r;
    r = '0;
    r.jump = 1'b1; r.jaddr = addr; r.stall = 1'b1;
    return r;
  endfunction

  // Architectural mstatus rules: trap entry saves MIE into MPIE, clears
  // MIE and sets MPP to machine; mret restores MIE from MPIE, sets MPIE
  function automatic logic [31:0] entry_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] m);
    return (m & ~32'h0000_0088) | (m[7] ? 32'h8 : 32'h0) | 32'h80;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk_i);
    bus.exception_i = s.exc;
    bus.inst_addr_i = s.pc;
    bus.mtvec_i     = s.mtvec;
    bus.mepc_i      = s.mepc;
    bus.mstatus_i   = s.ms;
    bus.timer_irq_i = s.tirq;
    #1;
  endtask

  task automatic checkOutput(input string name, input resp_t e);
    resp_t a;
    a.we    = bus.csr_we_o;
    a.waddr = bus.csr_waddr_o;
    a.wdata = bus.csr_wdata_o;
    a.stall = bus.stallreq_o;
    a.jump  = bus.jump_flag_o;
    a.jaddr = bus.jump_addr_o;
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got we=%0b waddr=%h wdata=%h stall=%0b jump=%0b jaddr=%h, expected we=%0b waddr=%h wdata=%h stall=%0b jump=%0b jaddr=%h",
               name, a.we, a.waddr, a.wdata, a.stall, a.jump, a.jaddr,
               e.we, e.waddr, e.wdata, e.stall, e.jump, e.jaddr);
    end
  endtask

  // Push one vector into the table
  task automatic addVec(input stim_t s, input resp_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic buildTable();
    // Only ignored high exception bits: no response
    addVec(mk(32'hFFFF_FFFC, 32'h0, 32'h80, 32'h0, 32'h8, 1'b0), r_idle(1'b0));
    // Plain ecall; inst_addr and exception bits wander after acceptance
    addVec(mk(32'h2, 32'h100, 32'h80, 32'h0, 32'h8, 1'b0), r_idle(1'b1));
    addVec(mk(32'h2, 32'h555, 32'h80, 32'h0, 32'h8, 1'b0), r_wr(12'h341, 32'h100));
    addVec(mk(32'h0, 32'h104, 32'h80, 32'h0, 32'h8, 1'b0), r_wr(12'h342, 32'd11));
    addVec(mk(32'h1, 32'h108, 32'h80, 32'h0, 32'h8, 1'b0), r_wr(12'h300, 32'h1880));
    addVec(mk(32'h0, 32'h10c, 32'h80, 32'h0, 32'h8, 1'b0), r_jmp(32'h80));
    addVec(mk(32'h0, 32'h110, 32'h80, 32'h0, 32'h8, 1'b0), r_idle(1'b0));
    // mret; mepc only becomes 0x104 in the jump cycle
    addVec(mk(32'h1, 32'h200, 32'h80, 32'h0, 32'h1880, 1'b0), r_idle(1'b1));
    addVec(mk(32'h0, 32'h200, 32'h80, 32'h0, 32'h1880, 1'b0), r_wr(12'h300, 32'h1888));
    addVec(mk(32'h0, 32'h200, 32'h80, 32'h104, 32'h1888, 1'b0), r_jmp(32'h104));
    addVec(mk(32'h0, 32'h200, 32'h80, 32'h104, 32'h1888, 1'b0), r_idle(1'b0));
    // ecall and mret together: ecall wins
    addVec(mk(32'h3, 32'h300, 32'h40, 32'h999, 32'h0, 1'b0), r_idle(1'b1));
    addVec(mk(32'h3, 32'h304, 32'h40, 32'h999, 32'h0, 1'b0), r_wr(12'h341, 32'h300));
    addVec(mk(32'h3, 32'h308, 32'h40, 32'h999, 32'h0, 1'b0), r_wr(12'h342, 32'd11));
    addVec(mk(32'h3, 32'h30c, 32'h40, 32'h999, 32'h0, 1'b0), r_wr(12'h300, 32'h1800));
    addVec(mk(32'h0, 32'h310, 32'h40, 32'h999, 32'h0, 1'b0), r_jmp(32'h40));
    addVec(mk(32'h0, 32'h314, 32'h40, 32'h999, 32'h0, 1'b0), r_idle(1'b0));
    // mtvec mode bits are masked off the target
    addVec(mk(32'h2, 32'h400, 32'h83, 32'h0, 32'h8, 1'b0), r_idle(1'b1));
    addVec(mk(32'h0, 32'h404, 32'h83, 32'h0, 32'h8, 1'b0), r_wr(12'h341, 32'h400));
    addVec(mk(32'h0, 32'h404, 32'h83, 32'h0, 32'h8, 1'b0), r_wr(12'h342, 32'd11));
    addVec(mk(32'h0, 32'h404, 32'h83, 32'h0, 32'h8, 1'b0), r_wr(12'h300, 32'h1880));
    addVec(mk(32'h0, 32'h404, 32'h83, 32'h0, 32'h8, 1'b0), r_jmp(32'h80));
    addVec(mk(32'h0, 32'h404, 32'h83, 32'h0, 32'h8, 1'b0), r_idle(1'b0));
  endtask

  // Reference model: when idle, turn the presented request into the full
  // list of per-cycle responses the architecture demands
  task automatic modelAccept(input stim_t s);
    logic        take_trap;
    logic [31:0] cause;
    take_trap = s.exc[1] || (IRQ_EN && s.tirq && s.ms[3]);
    cause     = s.exc[1] ? 32'd11 : 32'h8000_0007;
    if (take_trap) begin
      exp_q.push_back(r_idle(1'b1));
      exp_q.push_back(r_wr(12'h341, s.pc));
      exp_q.push_back(r_wr(12'h342, cause));
      exp_q.push_back(r_wr(12'h300, entry_ms(s.ms)));
      exp_q.push_back(r_jmp({s.mtvec[31:2], 2'b00}));
    end else if (s.exc[0]) begin
      exp_q.push_back(r_idle(1'b1));
      exp_q.push_back(r_wr(12'h300, mret_ms(s.ms)));
      exp_q.push_back(r_jmp(s.mepc));
    end else begin
      exp_q.push_back(r_idle(1'b0));
    end
  endtask

  initial begin
    stim_t s;
    resp_t e;
    tests = 0;
    fails = 0;

    // Reset state
    rst_i = 1'b1;
    bus.exception_i = '0;
    bus.inst_addr_i = '0;
    bus.mtvec_i     = '0;
    bus.mepc_i      = '0;
    bus.mstatus_i   = '0;
    bus.timer_irq_i = 1'b0;
    #1;
    checkOutput("reset_state", r_idle(1'b0));
    repeat (2) @(negedge clk_i);
    checkOutput("reset_held", r_idle(1'b0));
    rst_i = 1'b0;

    // Table of per-cycle vectors
    buildTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("table[%0d]", i), vecs[i].exp);
    end

    // Reset during the mcause cycle aborts the sequence
    applyStimulus(mk(32'h2, 32'h100, 32'h80, 32'h0, 32'h8, 1'b0));
    checkOutput("abort_c0", r_idle(1'b1));
    applyStimulus(mk(32'h0, 32'h100, 32'h80, 32'h0, 32'h8, 1'b0));
    checkOutput("abort_c1", r_wr(12'h341, 32'h100));
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("abort_rst", r_idle(1'b0));
    applyStimulus(mk(32'h0, 32'h100, 32'h80, 32'h0, 32'h8, 1'b0));
    checkOutput("abort_rst_hold", r_idle(1'b0));
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(32'h0, 32'h100, 32'h80, 32'h0, 32'h8, 1'b0));
      checkOutput($sformatf("abort_after[%0d]", i), r_idle(1'b0));
    end

    // Timer interrupt path
`ifdef TRAP_TIMER_IRQ_EN
    applyStimulus(mk(32'h0, 32'h200, 32'h80, 32'h0, 32'h8, 1'b1));
    checkOutput("irq_c0", r_idle(1'b1));
    applyStimulus(mk(32'h0, 32'h204, 32'h80, 32'h0, 32'h8, 1'b1));
    checkOutput("irq_mepc", r_wr(12'h341, 32'h200));
    applyStimulus(mk(32'h0, 32'h204, 32'h80, 32'h0, 32'h8, 1'b1));
    checkOutput("irq_mcause", r_wr(12'h342, 32'h8000_0007));
    applyStimulus(mk(32'h0, 32'h204, 32'h80, 32'h0, 32'h8, 1'b1));
    checkOutput("irq_mstatus", r_wr(12'h300, 32'h1880));
    applyStimulus(mk(32'h0, 32'h204, 32'h80, 32'h0, 32'h1880, 1'b1));
    checkOutput("irq_jump", r_jmp(32'h80));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(32'h0, 32'h200, 32'h80, 32'h0, 32'h0, 1'b1));
      checkOutput($sformatf("irq_masked[%0d]", i), r_idle(1'b0));
    end
`else
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(32'h0, 32'h200, 32'h80, 32'h0, 32'h8, 1'b1));
      checkOutput($sformatf("irq_ignored[%0d]", i), r_idle(1'b0));
    end
`endif

    // Randomized run against the reference model; CSR values are held for
    // a whole sequence, request lines and PC keep changing underneath it
    s = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] low;
      low = 32'($urandom_range(0, 5));
      if (low > 32'd3) low = 32'd0;
      if (exp_q.size() == 0) begin
        s.exc   = ($urandom() & 32'hFFFF_FFFC) | low;
        s.pc    = $urandom();
        s.mtvec = $urandom();
        s.mepc  = $urandom();
        s.ms    = $urandom();
        s.tirq  = 1'($urandom_range(0, 1));
        modelAccept(s);
      end else begin
        s.exc  = ($urandom() & 32'hFFFF_FFFC) | low;
        s.pc   = $urandom();
        s.tirq = 1'($urandom_range(0, 1));
      end
      applyStimulus(s);
      e = exp_q.pop_front();
      checkOutput($sformatf("random[%0d]", n), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
